// File: rtl/ysyx_220053_ifetch_buf.sv
// Instruction fetch stage: accepts a pc, issues one imem read, selects the 32-bit word
// and queues {pc, inst, err} toward decode. Flush discards queued and in-flight fetches.
module ysyx_220053_ifetch_buf #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc_i,
   input  logic          pc_valid_i,
   output logic          pc_ready_o,
   output logic          imem_req_o,
   output logic [AW-1:0] imem_addr_o,
   input  logic          imem_gnt_i,
   input  logic          imem_rvalid_i,
   input  logic [63:0]   imem_rdata_i,
   input  logic          flush_i,
   output logic          inst_valid_o,
   output logic [31:0]   inst_o,
   output logic [AW-1:0] inst_pc_o,
   output logic          inst_err_o,
   input  logic          inst_ready_i
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = 32;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    pc_q, pc_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [AW-1:0]    pc_mem_q   [DEPTH];
   logic [AW-1:0]    pc_mem_d   [DEPTH];
   logic [IW-1:0]    inst_mem_q [DEPTH];
   logic [IW-1:0]    inst_mem_d [DEPTH];
   logic [DEPTH-1:0] err_mem_q, err_mem_d;

   logic          space;
   logic          push, push_ok, pop;
   logic [AW-1:0] push_pc;
   logic [IW-1:0] push_inst;
   logic          push_err;

   assign space = (count_q < CW'(DEPTH));
   assign pop   = (count_q != '0) & inst_ready_i;

   // Fetch control: at most one read outstanding; DROP swallows a read orphaned by flush
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      push       = 1'b0;
      push_pc    = pc_q;
      push_inst  = '0;
      push_err   = 1'b0;
      pc_ready_o = 1'b0;
      imem_req_o = 1'b0;
      case (state_q)
         IDLE: begin
            pc_ready_o = rst & ~flush_i & space;
            if (pc_valid_i && rst && !flush_i && space) begin
               pc_d = pc_i;
               if (pc_i[1:0] != 2'b00) begin
                  push     = 1'b1;
                  push_pc  = pc_i;
                  push_err = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            imem_req_o = 1'b1;
            if (flush_i) begin
               state_d = IDLE;
            end else if (imem_gnt_i) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               state_d = IDLE;
               if (!flush_i) begin
                  push      = 1'b1;
                  push_inst = pc_q[2] ? imem_rdata_i[63:32] : imem_rdata_i[31:0];
               end
            end else if (flush_i) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (imem_rvalid_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign push_ok = push & (space | pop);

   // Output FIFO; flush overrides any same-cycle push or pop
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      err_mem_d  = err_mem_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            pc_mem_d[wr_ptr_q]   = push_pc;
            inst_mem_d[wr_ptr_q] = push_inst;
            err_mem_d[wr_ptr_q]  = push_err;
            wr_ptr_d             = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push_ok) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_mem_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_mem_q  <= err_mem_d;
         pc_mem_q   <= pc_mem_d;
         inst_mem_q <= inst_mem_d;
      end
   end

   assign imem_addr_o  = {pc_q[AW-1:3], 3'b000};
   assign inst_valid_o = (count_q != '0);
   assign inst_o       = inst_mem_q[rd_ptr_q];
   assign inst_pc_o    = pc_mem_q[rd_ptr_q];
   assign inst_err_o   = err_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ysyx_220053_ifetch_buf.sv
// Bench for ysyx_220053_ifetch_buf: directed scenarios plus a randomized run, with a
// queue-based reference of which fetches must reach decode and with what contents.
module tb_ysyx_220053_ifetch_buf;
   localparam int unsigned AW    = 64;
   localparam int unsigned DEPTH = 2;

   logic          clk;
   logic          rst;
   logic [AW-1:0] pc_i;
   logic          pc_valid_i;
   logic          pc_ready_o;
   logic          imem_req_o;
   logic [AW-1:0] imem_addr_o;
   logic          imem_gnt_i;
   logic          imem_rvalid_i;
   logic [63:0]   imem_rdata_i;
   logic          flush_i;
   logic          inst_valid_o;
   logic [31:0]   inst_o;
   logic [AW-1:0] inst_pc_o;
   logic          inst_err_o;
   logic          inst_ready_i;

   ysyx_220053_ifetch_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .pc_valid_i   (pc_valid_i),
      .pc_ready_o   (pc_ready_o),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_gnt_i   (imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .flush_i      (flush_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o),
      .inst_err_o   (inst_err_o),
      .inst_ready_i (inst_ready_i)
   );

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [31:0]   inst;
      logic          err;
   } entry_t;

   int            n_checks = 0;
   int            n_pass   = 0;
   entry_t        exp_q[$];
   bit            infl     = 1'b0;
   logic [AW-1:0] infl_pc  = '0;
   bit            mem_rand = 1'b0;
   int            rv_delay = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   // Memory image: one doubleword per aligned address, both halves distinct
   function automatic logic [63:0] mem64(input logic [AW-1:0] a);
      if (a == 64'h8000_0000) return 64'h0010_0073_0000_0413;
      return {a[31:0] ^ 32'hdead_beef, a[63:32] ^ {a[28:0], 3'b101}};
   endfunction

   function automatic entry_t expect_entry(input logic [AW-1:0] pc);
      entry_t      e;
      logic [63:0] d;
      e.pc = pc;
      if (pc[1:0] != 2'b00) begin
         e.inst = '0;
         e.err  = 1'b1;
      end else begin
         d      = mem64({pc[AW-1:3], 3'b000});
         e.inst = pc[2] ? d[63:32] : d[31:0];
         e.err  = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [AW-1:0] rand_pc();
      logic [AW-1:0] p;
      p = 64'h8000_0000 + 64'($urandom_range(0, 4095) & 32'hffff_fffc);
      if ($urandom_range(0, 4) == 0) p[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) p[63:32] = $urandom;
      return p;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   // Reference model and output monitor
   always @(negedge clk) begin : model
      entry_t e;
      if (!rst || flush_i) begin
         exp_q.delete();
         infl = 1'b0;
      end else begin
         if (inst_valid_o && inst_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL pop_unexpected: got pc %h inst %h err %b, required no output",
                        inst_pc_o, inst_o, inst_err_o);
            end else begin
               e = exp_q.pop_front();
               if (inst_pc_o === e.pc && inst_o === e.inst && inst_err_o === e.err) n_pass++;
               else $display("FAIL pop_data: got pc %h inst %h err %b, required pc %h inst %h err %b",
                             inst_pc_o, inst_o, inst_err_o, e.pc, e.inst, e.err);
            end
         end
         if (imem_req_o) begin
            n_checks++;
            if (infl && imem_addr_o === {infl_pc[AW-1:3], 3'b000}) n_pass++;
            else $display("FAIL req_addr: got req addr %h, required %h (fetch pending %0d)",
                          imem_addr_o, {infl_pc[AW-1:3], 3'b000}, infl);
         end
         if (imem_rvalid_i && infl) begin
            exp_q.push_back(expect_entry(infl_pc));
            infl = 1'b0;
         end
         if (pc_valid_i && pc_ready_o) begin
            if (pc_i[1:0] != 2'b00) exp_q.push_back(expect_entry(pc_i));
            else begin
               infl    = 1'b1;
               infl_pc = pc_i;
            end
         end
      end
   end

   // Instruction memory: grants never during flush, one rvalid per grant, cleared by reset
   initial begin : mem
      bit            pend;
      int            wcnt;
      logic [AW-1:0] paddr;
      pend          = 1'b0;
      wcnt          = 0;
      paddr         = '0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      forever begin
         @(posedge clk);
         #2;
         imem_gnt_i    = 1'b0;
         imem_rvalid_i = 1'b0;
         if (!rst) begin
            pend = 1'b0;
         end else if (pend) begin
            if (wcnt == 0) begin
               imem_rvalid_i = 1'b1;
               imem_rdata_i  = mem64(paddr);
               pend          = 1'b0;
            end else begin
               wcnt--;
            end
         end else if (imem_req_o && !flush_i && (!mem_rand || $urandom_range(0, 1) == 1)) begin
            imem_gnt_i = 1'b1;
            pend       = 1'b1;
            paddr      = imem_addr_o;
            wcnt       = mem_rand ? int'($urandom_range(0, 3)) : rv_delay;
         end
      end
   end

   task automatic offer(input logic [AW-1:0] pc);
      bit done;
      done       = 1'b0;
      pc_i       = pc;
      pc_valid_i = 1'b1;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (pc_ready_o) done = 1'b1;
      end
      @(posedge clk);
      #1;
      pc_valid_i = 1'b0;
      chk("pc_accepted", 64'(done), 64'd1);
   endtask

   task automatic wait_gnt();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (imem_gnt_i && imem_req_o) seen = 1'b1;
      end
      chk("grant_seen", 64'(seen), 64'd1);
   endtask

   task automatic drain();
      int k;
      k            = 0;
      inst_ready_i = 1'b1;
      pc_valid_i   = 1'b0;
      @(negedge clk);
      while ((exp_q.size() != 0 || infl || inst_valid_o) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      chk("drain_valid", 64'(inst_valid_o), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int lat;
      bit acc;
      rst          = 1'b0;
      pc_i         = 64'h8000_0000;
      pc_valid_i   = 1'b1;
      flush_i      = 1'b0;
      inst_ready_i = 1'b1;

      // reset with pc offered
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_req", 64'(imem_req_o), 64'd0);
      chk("rst_pc_ready", 64'(pc_ready_o), 64'd0);
      chk("rst_valid", 64'(inst_valid_o), 64'd0);
      chk("rst_inst", 64'(inst_o), 64'd0);
      @(posedge clk);
      #1;
      rst        = 1'b1;
      pc_valid_i = 1'b0;

      // aligned fetch, low word, zero-wait memory
      mem_rand = 1'b0;
      rv_delay = 0;
      offer(64'h8000_0000);
      lat = 1;
      @(negedge clk);
      while (!inst_valid_o && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 64'(lat), 64'd3);
      chk("inst_lo", 64'(inst_o), 64'h0000_0413);
      chk("inst_pc_lo", inst_pc_o, 64'h8000_0000);
      @(posedge clk);
      #1;

      // upper word of the same doubleword
      offer(64'h8000_0004);
      @(negedge clk);
      chk("addr_aligned", imem_addr_o, 64'h8000_0000);
      lat = 1;
      while (!inst_valid_o && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("inst_hi", 64'(inst_o), 64'h0010_0073);
      @(posedge clk);
      #1;
      drain();

      // backpressure: two entries queued, third pc held off
      inst_ready_i = 1'b0;
      offer(64'h8000_0010);
      offer(64'h8000_0014);
      pc_i       = 64'h8000_0018;
      pc_valid_i = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("full_pc_ready", 64'(pc_ready_o), 64'd0);
      chk("full_valid", 64'(inst_valid_o), 64'd1);
      chk("full_head_pc", inst_pc_o, 64'h8000_0010);
      @(posedge clk);
      #1;
      inst_ready_i = 1'b1;
      offer(64'h8000_0018);
      drain();

      // flush while waiting for read data; late data must vanish
      rv_delay = 2;
      offer(64'h8000_0040);
      wait_gnt();
      @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("flush_valid", 64'(inst_valid_o), 64'd0);
      chk("flush_back_idle", 64'(pc_ready_o), 64'd1);
      @(posedge clk);
      #1;
      rv_delay = 0;
      offer(64'h8000_0100);
      drain();

      // misaligned pc bypasses memory
      offer(64'h8000_0002);
      @(negedge clk);
      chk("mis_req", 64'(imem_req_o), 64'd0);
      chk("mis_valid", 64'(inst_valid_o), 64'd1);
      chk("mis_err", 64'(inst_err_o), 64'd1);
      chk("mis_inst", 64'(inst_o), 64'd0);
      @(posedge clk);
      #1;
      drain();

      // reset during WAIT with one entry queued
      inst_ready_i = 1'b0;
      rv_delay     = 6;
      offer(64'h8000_0006);
      offer(64'h8000_0200);
      wait_gnt();
      chk("pre_rst_valid", 64'(inst_valid_o), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst2_req", 64'(imem_req_o), 64'd0);
      chk("rst2_valid", 64'(inst_valid_o), 64'd0);
      chk("rst2_pc_ready", 64'(pc_ready_o), 64'd0);
      chk("rst2_inst", 64'(inst_o), 64'd0);
      chk("rst2_pc", inst_pc_o, 64'd0);
      chk("rst2_err", 64'(inst_err_o), 64'd0);
      @(posedge clk);
      #1;
      rst          = 1'b1;
      inst_ready_i = 1'b1;
      rv_delay     = 0;
      offer(64'h8000_0300);
      drain();

      // randomized traffic
      mem_rand   = 1'b1;
      pc_valid_i = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         acc = pc_valid_i && pc_ready_o;
         @(posedge clk);
         #1;
         if (acc || !pc_valid_i) begin
            pc_valid_i = ($urandom_range(0, 3) != 0);
            pc_i       = rand_pc();
         end
         inst_ready_i = ($urandom_range(0, 3) != 0);
         flush_i      = ($urandom_range(0, 19) == 0);
      end
      flush_i = 1'b0;
      drain();
      mem_rand = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
